// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the generic up/down counter.
package updown_counter_pkg;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Loaded values above the modulus limit are pulled down to the limit.
  function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max_val);
    return (val > max_val) ? max_val : val;
  endfunction

endpackage

// File: rtl/updown_prescaler.sv
// Counts enabled cycles 0..PRESCALE-1 and ticks on the last one.
// Only built when UPDOWN_PRESCALE_EN is defined.
`ifdef UPDOWN_PRESCALE_EN
module updown_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_reg;

  assign tick = en & (cnt_reg == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule
`endif

// File: rtl/updown_counter_gen.sv
// Parametrised up/down counter with modulus, wrap/saturate, load, tc pulse and
// sticky ovf/udf flags. Define UPDOWN_PRESCALE_EN to step only every PRESCALE enables.
module updown_counter_gen
  import updown_counter_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             udf
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);

  if (WIDTH < 2 || PRESCALE < 1 || MAX_VAL < 0 || MAX_VAL > 2**WIDTH - 1) begin : g_bad_param
    $error("updown_counter_gen: illegal WIDTH/MAX_VAL/PRESCALE combination");
  end

  logic [WIDTH-1:0] count_reg, count_next;
  logic             tc_reg, tc_next;
  logic             ovf_reg, udf_reg;
  logic             ovf_set, udf_set;
  logic             step;

`ifdef UPDOWN_PRESCALE_EN
  logic tick;

  // Load also restarts the prescale phase.
  updown_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (load),
    .tick (tick)
  );

  assign step = tick & ~load;
`else
  assign step = en & ~load;
`endif

  always_comb begin
    count_next = count_reg;
    tc_next    = 1'b0;
    ovf_set    = 1'b0;
    udf_set    = 1'b0;
    if (load) begin
      count_next = WIDTH'(clamp_load(32'(load_val), 32'(MAX_VAL)));
    end else if (step) begin
      if (up_down) begin
        if (count_reg == MAX_W) begin
          tc_next    = 1'b1;
          ovf_set    = 1'b1;
          count_next = (SATURATE == MODE_WRAP) ? '0 : MAX_W;
        end else begin
          count_next = count_reg + 1'b1;
        end
      end else begin
        if (count_reg == '0) begin
          tc_next    = 1'b1;
          udf_set    = 1'b1;
          count_next = (SATURATE == MODE_WRAP) ? MAX_W : '0;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
    end
  end

  // A new limit event outranks a same-cycle flag clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
      tc_reg    <= 1'b0;
      ovf_reg   <= 1'b0;
      udf_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      tc_reg    <= tc_next;
      ovf_reg   <= ovf_set | (ovf_reg & ~clr_flags);
      udf_reg   <= udf_set | (udf_reg & ~clr_flags);
    end
  end

  assign count = count_reg;
  assign tc    = tc_reg;
  assign ovf   = ovf_reg;
  assign udf   = udf_reg;

endmodule

// File: tb/tb_updown_counter_gen.sv
// Self-checking bench: a wrap and a saturate instance (WIDTH=4, MAX_VAL=9) driven in
// parallel, checked against vector tables, corner sequences and a behavioural model.
module tb_updown_counter_gen;

  localparam int W  = 4;
  localparam int MX = 9;
  localparam int P  = 4;
`ifdef UPDOWN_PRESCALE_EN
  localparam int PS = P;
`else
  localparam int PS = 1;
`endif

  logic         clk = 1'b0;
  logic         reset, en, up_down, load, clr_flags;
  logic [W-1:0] load_val;
  logic [W-1:0] cw, cs;
  logic         tcw, ow, uw, tcs, os, us;

  always #5 clk = ~clk;

  updown_counter_gen #(.WIDTH(W), .MAX_VAL(MX), .SATURATE(0), .PRESCALE(P)) dut_w (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(cw), .tc(tcw), .ovf(ow), .udf(uw)
  );

  updown_counter_gen #(.WIDTH(W), .MAX_VAL(MX), .SATURATE(1), .PRESCALE(P)) dut_s (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load),
    .load_val(load_val), .clr_flags(clr_flags),
    .count(cs), .tc(tcs), .ovf(os), .udf(us)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference state, index 0 = wrap instance, 1 = saturate instance.
  int m_cnt[2], m_tc[2], m_ovf[2], m_udf[2], m_pre[2];

  typedef struct {
    bit       en, up, ld;
    bit [3:0] lv;
    bit       clr;
    int       c, t, o, u;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_tc[i] = 0; m_ovf[i] = 0; m_udf[i] = 0; m_pre[i] = 0;
    end
  endfunction

  function automatic void model_edge();
    for (int i = 0; i < 2; i++) begin
      bit set_o = 0;
      bit set_u = 0;
      m_tc[i] = 0;
      if (load) begin
        m_cnt[i] = (int'(load_val) > MX) ? MX : int'(load_val);
        m_pre[i] = 0;
      end else if (en) begin
        m_pre[i] = m_pre[i] + 1;
        if (m_pre[i] == PS) begin
          m_pre[i] = 0;
          if (up_down) begin
            if (m_cnt[i] == MX) begin
              m_tc[i] = 1; set_o = 1;
              m_cnt[i] = (i == 1) ? MX : 0;
            end else m_cnt[i] = m_cnt[i] + 1;
          end else begin
            if (m_cnt[i] == 0) begin
              m_tc[i] = 1; set_u = 1;
              m_cnt[i] = (i == 1) ? 0 : MX;
            end else m_cnt[i] = m_cnt[i] - 1;
          end
        end
      end
      m_ovf[i] = set_o ? 1 : (clr_flags ? 0 : m_ovf[i]);
      m_udf[i] = set_u ? 1 : (clr_flags ? 0 : m_udf[i]);
    end
  endfunction

  task automatic check_model(input string tag);
    chk({tag, "_w_count"}, int'(cw),  m_cnt[0]);
    chk({tag, "_w_tc"},    int'(tcw), m_tc[0]);
    chk({tag, "_w_ovf"},   int'(ow),  m_ovf[0]);
    chk({tag, "_w_udf"},   int'(uw),  m_udf[0]);
    chk({tag, "_s_count"}, int'(cs),  m_cnt[1]);
    chk({tag, "_s_tc"},    int'(tcs), m_tc[1]);
    chk({tag, "_s_ovf"},   int'(os),  m_ovf[1]);
    chk({tag, "_s_udf"},   int'(us),  m_udf[1]);
  endtask

  task automatic cycle(input bit e, input bit u, input bit ld, input bit [3:0] lv, input bit c);
    en = e; up_down = u; load = ld; load_val = lv; clr_flags = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    //         en up ld lv   clr  cnt tc ovf udf
    tbl[0]  = '{0, 0, 1, 4'd8,  0, 8, 0, 0, 0};
    tbl[1]  = '{1, 1, 0, 4'd0,  0, 9, 0, 0, 0};
    tbl[2]  = '{1, 1, 0, 4'd0,  0, 0, 1, 1, 0};
    tbl[3]  = '{1, 1, 0, 4'd0,  0, 1, 0, 1, 0};
    tbl[4]  = '{0, 1, 0, 4'd0,  0, 1, 0, 1, 0};
    tbl[5]  = '{1, 0, 0, 4'd0,  0, 0, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 4'd0,  0, 9, 1, 1, 1};
    tbl[7]  = '{1, 1, 1, 4'd15, 0, 9, 0, 1, 1};
    tbl[8]  = '{0, 0, 0, 4'd0,  1, 9, 0, 0, 0};
    tbl[9]  = '{1, 1, 0, 4'd0,  1, 0, 1, 1, 0};
    tbl[10] = '{0, 0, 1, 4'd3,  0, 3, 0, 1, 0};
    tbl[11] = '{1, 0, 0, 4'd0,  0, 2, 0, 1, 0};

    reset = 1'b1; en = 0; up_down = 0; load = 0; load_val = '0; clr_flags = 0;
    @(posedge clk); @(posedge clk); #1;
    model_reset();
    check_model("reset");
    reset = 1'b0;

`ifndef UPDOWN_PRESCALE_EN
    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].en, tbl[i].up, tbl[i].ld, tbl[i].lv, tbl[i].clr);
      chk($sformatf("vec%0d_count", i), int'(cw),  tbl[i].c);
      chk($sformatf("vec%0d_tc", i),    int'(tcw), tbl[i].t);
      chk($sformatf("vec%0d_ovf", i),   int'(ow),  tbl[i].o);
      chk($sformatf("vec%0d_udf", i),   int'(uw),  tbl[i].u);
      chk($sformatf("vec%0d_sat_count", i), int'(cs), m_cnt[1]);
      chk($sformatf("vec%0d_sat_tc", i),    int'(tcs), m_tc[1]);
    end
`endif

    // Saturate: repeated up steps at the limit hold and pulse tc every step.
    cycle(0, 0, 1, 4'd9, 1);
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < PS; j++) cycle(1, 1, 0, 4'd0, 0);
      chk($sformatf("sat_hold%0d_count", k), int'(cs),  9);
      chk($sformatf("sat_hold%0d_tc", k),    int'(tcs), 1);
      chk($sformatf("sat_hold%0d_ovf", k),   int'(os),  1);
      check_model($sformatf("sat_hold%0d", k));
    end

    // Asynchronous reset mid-count takes effect before the next edge.
    cycle(0, 0, 1, 4'd5, 0);
    chk("pre_reset_count", int'(cw), 5);
    reset = 1'b1;
    #1;
    model_reset();
    chk("async_reset_count", int'(cw), 0);
    chk("async_reset_tc",    int'(tcw), 0);
    chk("async_reset_ovf",   int'(ow), 0);
    chk("async_reset_udf",   int'(uw), 0);
    chk("async_reset_s_ovf", int'(os), 0);
    load = 1'b1; load_val = 4'd7; en = 1'b1;
    @(posedge clk); #1;
    chk("load_with_reset_count", int'(cw), 0);
    reset = 1'b0; load = 1'b0; en = 1'b0;

`ifdef UPDOWN_PRESCALE_EN
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 1, 0, 4'd0, 0);
      if (k == 3) chk("pre_edge3_count", int'(cw), 0);
      if (k == 4) chk("pre_edge4_count", int'(cw), 1);
      if (k == 7) chk("pre_edge7_count", int'(cw), 1);
      if (k == 8) chk("pre_edge8_count", int'(cw), 2);
    end
    check_model("pre_done");
`endif

    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) < 2) begin
        reset = 1'b1;
        #1;
        model_reset();
        check_model("rand_reset");
        @(posedge clk); #1;
        reset = 1'b0;
      end else begin
        bit e, u, ld, c;
        bit [3:0] lv;
        e  = ($urandom_range(0, 3) != 0);
        u  = 1'($urandom);
        ld = ($urandom_range(0, 15) == 0);
        lv = 4'($urandom);
        c  = !ld && ($urandom_range(0, 7) == 0);
        cycle(e, u, ld, lv, c);
        check_model($sformatf("rand%0d", n));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
